// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath widths, control-bundle bit positions and
// the three-state encoding of the ID/EX pipeline register.
package cpu_pkg;
  localparam int XLEN          = 32;
  localparam int CTRL_W        = 16;
  localparam int CTRL_MEMREAD  = 0;
  localparam int CTRL_REGWRITE = 1;

  localparam logic [1:0] ST_EMPTY = 2'd0;  // nothing presented to execute
  localparam logic [1:0] ST_LIVE  = 2'd1;  // first presentation, operands from RF + forwarding
  localparam logic [1:0] ST_HELD  = 2'd2;  // stalled, operands from capture registers
endpackage

// File: rtl/operand_fwd_mux.sv
// Priority operand select for one source register:
// x0 -> 0, then EX/MEM match, then MEM/WB match, then the base value.
module operand_fwd_mux #(
  parameter int XLEN = cpu_pkg::XLEN
) (
  input  logic [4:0]      rs,
  input  logic            exm_we,
  input  logic [4:0]      exm_rd,
  input  logic [XLEN-1:0] exm_data,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic [XLEN-1:0] base,
  output logic [XLEN-1:0] op
);
  // Youngest producer wins; x0 is hardwired to zero regardless of producers.
  always_comb begin
    op = base;
    if (rs == 5'd0)                     op = '0;
    else if (exm_we && (exm_rd == rs))  op = exm_data;
    else if (wb_we && (wb_rd == rs))    op = wb_data;
  end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use bubble
// insertion, stall capture and flush.
module id_ex_stage #(
  parameter int XLEN   = cpu_pkg::XLEN,
  parameter int CTRL_W = cpu_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic [CTRL_W-1:0] id_ctrl,
  output logic [4:0]        rf_raddr1,
  output logic [4:0]        rf_raddr2,
  input  logic [XLEN-1:0]   rf_rdata1,
  input  logic [XLEN-1:0]   rf_rdata2,
  input  logic              exm_we,
  input  logic [4:0]        exm_rd,
  input  logic [XLEN-1:0]   exm_data,
  input  logic              wb_we,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              ex_flush,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_imm,
  output logic [XLEN-1:0]   ex_op1,
  output logic [XLEN-1:0]   ex_op2,
  output logic [4:0]        ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl
);
  import cpu_pkg::*;

  logic [1:0]        state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d, imm_q, imm_d;
  logic [XLEN-1:0]   cap1_q, cap1_d, cap2_q, cap2_d;
  logic [4:0]        rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              live, held, hazard, accept, exm_live;
  logic [XLEN-1:0]   base1, base2, fwd1, fwd2;

  // Handshake, hazard detection and operand source selection.
  always_comb begin
    live      = (state_q == ST_LIVE);
    held      = (state_q == ST_HELD);
    rf_raddr1 = id_rs1;
    rf_raddr2 = id_rs2;
    hazard    = (state_q != ST_EMPTY) && ctrl_q[CTRL_MEMREAD] && (rd_q != 5'd0) &&
                id_valid && ((rd_q == id_rs1) || (rd_q == id_rs2));
    id_ready  = ((state_q == ST_EMPTY) || ex_ready) && !hazard && !ex_flush;
    accept    = id_valid && id_ready;
    // While held, the EX/MEM producer has already moved on; only WB can refresh captures.
    exm_live  = exm_we && live;
    base1     = held ? cap1_q : rf_rdata1;
    base2     = held ? cap2_q : rf_rdata2;
  end

  operand_fwd_mux #(.XLEN(XLEN)) u_fwd1 (
    .rs(rs1_q), .exm_we(exm_live), .exm_rd(exm_rd), .exm_data(exm_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .base(base1), .op(fwd1));

  operand_fwd_mux #(.XLEN(XLEN)) u_fwd2 (
    .rs(rs2_q), .exm_we(exm_live), .exm_rd(exm_rd), .exm_data(exm_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .base(base2), .op(fwd2));

  // Outputs: forwarded operands on first presentation, captured ones afterwards.
  always_comb begin
    ex_valid = (state_q != ST_EMPTY);
    ex_pc    = pc_q;
    ex_imm   = imm_q;
    ex_rd    = rd_q;
    ex_ctrl  = ctrl_q;
    ex_op1   = live ? fwd1 : cap1_q;
    ex_op2   = live ? fwd2 : cap2_q;
  end

  // Next-state: flush dominates, then consume/accept, otherwise stall.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    imm_d   = imm_q;
    rd_d    = rd_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    ctrl_d  = ctrl_q;
    cap1_d  = cap1_q;
    cap2_d  = cap2_q;
    if (ex_flush)                                state_d = ST_EMPTY;
    else if ((state_q == ST_EMPTY) || ex_ready)  state_d = accept ? ST_LIVE : ST_EMPTY;
    else                                         state_d = ST_HELD;
    if (accept) begin
      pc_d   = id_pc;
      imm_d  = id_imm;
      rd_d   = id_rd;
      rs1_d  = id_rs1;
      rs2_d  = id_rs2;
      ctrl_d = id_ctrl;
    end
    // Entering or staying in HELD: snapshot (LIVE) or WB-refresh (HELD) the operands.
    if (!ex_flush && !ex_ready && (state_q != ST_EMPTY)) begin
      cap1_d = fwd1;
      cap2_d = fwd2;
    end
  end

  // Pipeline register state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_EMPTY;
      pc_q    <= '0;
      imm_q   <= '0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      ctrl_q  <= '0;
      cap1_q  <= '0;
      cap2_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      imm_q   <= imm_d;
      rd_q    <= rd_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      ctrl_q  <= ctrl_d;
      cap1_q  <= cap1_d;
      cap2_q  <= cap2_d;
    end
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic checked
// against a transaction-level model of the presented instruction.
module tb_id_ex_stage;
  import cpu_pkg::*;

  logic        clk, resetn;
  logic        id_valid, id_ready;
  logic [31:0] id_pc, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [15:0] id_ctrl;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        exm_we, wb_we;
  logic [4:0]  exm_rd, wb_rd;
  logic [31:0] exm_data, wb_data;
  logic        ex_flush, ex_valid, ex_ready;
  logic [31:0] ex_pc, ex_imm, ex_op1, ex_op2;
  logic [4:0]  ex_rd;
  logic [15:0] ex_ctrl;

  id_ex_stage #(.XLEN(32), .CTRL_W(16)) dut (
    .clk(clk), .resetn(resetn), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_ctrl(id_ctrl), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .exm_we(exm_we), .exm_rd(exm_rd),
    .exm_data(exm_data), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_flush(ex_flush), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
    .ex_imm(ex_imm), .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file with synchronous read; contents fixed for the whole run.
  logic [31:0] regs [32];
  always @(posedge clk) begin
    rf_rdata1 <= regs[rf_raddr1];
    rf_rdata2 <= regs[rf_raddr2];
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: the instruction currently owned by the stage.
  bit          m_valid, m_first;
  logic [31:0] m_pc, m_imm, m_h1, m_h2;
  logic [4:0]  m_rd, m_rs1, m_rs2;
  logic [15:0] m_ctrl;

  function automatic logic [31:0] res(input logic [4:0] rs, input logic [31:0] base, input bit use_exm);
    if (rs == 0) return 32'd0;
    if (use_exm && exm_we && exm_rd == rs) return exm_data;
    if (wb_we && wb_rd == rs) return wb_data;
    return base;
  endfunction

  // One clock: check outputs at negedge against the model, advance model, return after posedge.
  task automatic cycle();
    logic [31:0] e1, e2;
    bit hz, rdy;
    @(negedge clk);
    e1 = m_first ? res(m_rs1, regs[m_rs1], 1'b1) : m_h1;
    e2 = m_first ? res(m_rs2, regs[m_rs2], 1'b1) : m_h2;
    hz = m_valid && m_ctrl[CTRL_MEMREAD] && m_rd != 0 && id_valid &&
         (m_rd == id_rs1 || m_rd == id_rs2);
    rdy = (!m_valid || ex_ready) && !hz && !ex_flush;
    chk("id_ready", id_ready, rdy);
    chk("ex_valid", ex_valid, m_valid);
    chk("rf_raddr1", rf_raddr1, id_rs1);
    chk("rf_raddr2", rf_raddr2, id_rs2);
    if (m_valid) begin
      chk("ex_pc", ex_pc, m_pc);
      chk("ex_imm", ex_imm, m_imm);
      chk("ex_rd", ex_rd, m_rd);
      chk("ex_ctrl", ex_ctrl, m_ctrl);
      chk("ex_op1", ex_op1, e1);
      chk("ex_op2", ex_op2, e2);
    end
    if (ex_flush) m_valid = 0;
    else if (!m_valid || ex_ready) begin
      if (id_valid && rdy) begin
        m_valid = 1; m_first = 1;
        m_pc = id_pc; m_imm = id_imm; m_rd = id_rd; m_ctrl = id_ctrl;
        m_rs1 = id_rs1; m_rs2 = id_rs2;
      end else m_valid = 0;
    end else begin
      if (m_first) begin m_h1 = e1; m_h2 = e2; end
      else begin m_h1 = res(m_rs1, m_h1, 1'b0); m_h2 = res(m_rs2, m_h2, 1'b0); end
      m_first = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    id_valid = 0; exm_we = 0; wb_we = 0; ex_flush = 0; ex_ready = 1;
  endtask

  task automatic drv(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd, input logic [15:0] ctrl);
    id_valid = 1; id_pc = pc; id_imm = $urandom; id_rs1 = rs1; id_rs2 = rs2;
    id_rd = rd; id_ctrl = ctrl;
  endtask

  localparam logic [15:0] C_ALU  = 16'h0002;  // REGWRITE
  localparam logic [15:0] C_LOAD = 16'h0003;  // MEMREAD | REGWRITE

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0] = 32'hDEAD_BEEF;  // x0 must still read as zero
    regs[1] = 32'd5; regs[2] = 32'd7; regs[6] = 32'h66;
    m_valid = 0; m_first = 0; m_h1 = 0; m_h2 = 0;
    m_pc = 0; m_imm = 0; m_rd = 0; m_rs1 = 0; m_rs2 = 0; m_ctrl = 0;
    resetn = 0; idle();
    id_pc = 0; id_imm = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_ctrl = 0;
    exm_rd = 0; exm_data = 0; wb_rd = 0; wb_data = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_ex_pc", ex_pc, 0);
    chk("rst_ex_op1", ex_op1, 0);
    chk("rst_ex_op2", ex_op2, 0);
    chk("rst_ex_ctrl", ex_ctrl, 0);
    chk("rst_ex_rd", ex_rd, 0);
    resetn = 1;

    // Basic accept, latency 1.
    drv(32'h100, 1, 2, 3, C_ALU); cycle();
    idle(); #1;
    chk("add_valid", ex_valid, 1); chk("add_op1", ex_op1, 5); chk("add_op2", ex_op2, 7);
    cycle();

    // EX/MEM beats MEM/WB; x0 never forwarded.
    drv(32'h110, 1, 2, 3, C_ALU); cycle();
    exm_we = 1; exm_rd = 1; exm_data = 32'hAA; wb_we = 1; wb_rd = 1; wb_data = 32'hBB;
    drv(32'h114, 0, 2, 3, C_ALU); #1;
    chk("fwd_exm_prio", ex_op1, 32'hAA);
    cycle();
    id_valid = 0; exm_rd = 0; wb_rd = 0; #1;
    chk("fwd_x0", ex_op1, 0);
    cycle();
    idle(); cycle();

    // Load-use: one bubble, then WB forward.
    drv(32'h120, 1, 2, 4, C_LOAD); cycle();
    drv(32'h124, 5, 4, 8, C_ALU); #1;
    chk("lu_stall", id_ready, 0);
    cycle();
    #1;
    chk("lu_bubble", ex_valid, 0); chk("lu_ready", id_ready, 1);
    cycle();
    id_valid = 0; wb_we = 1; wb_rd = 4; wb_data = 32'h1234; #1;
    chk("lu_valid", ex_valid, 1); chk("lu_op2", ex_op2, 32'h1234);
    cycle();
    idle(); cycle();

    // Stall with WB update of capture.
    drv(32'h200, 1, 6, 7, C_ALU); cycle();
    drv(32'h204, 2, 3, 9, C_ALU); ex_ready = 0; #1;
    chk("hold_ready", id_ready, 0);
    cycle();
    wb_we = 1; wb_rd = 6; wb_data = 32'h55; cycle();
    wb_we = 0; cycle();
    ex_ready = 1; #1;
    chk("hold_op2", ex_op2, 32'h55); chk("hold_pc", ex_pc, 32'h200); chk("hold_op1", ex_op1, 5);
    cycle();
    idle(); cycle();

    // Flush in LIVE, then reset in HELD.
    drv(32'h300, 1, 2, 3, C_ALU); cycle();
    drv(32'h304, 1, 2, 3, C_ALU); ex_flush = 1; #1;
    chk("flush_ready", id_ready, 0);
    cycle();
    idle(); #1;
    chk("flush_valid", ex_valid, 0);
    cycle();
    drv(32'h308, 1, 2, 3, C_ALU); cycle();
    id_valid = 0; ex_ready = 0; cycle();
    resetn = 0; #1;
    chk("rstmid_valid", ex_valid, 0); chk("rstmid_pc", ex_pc, 0); chk("rstmid_op2", ex_op2, 0);
    m_valid = 0; m_first = 0; m_h1 = 0; m_h2 = 0;
    #2 resetn = 1;
    drv(32'h30C, 1, 2, 3, C_ALU); ex_ready = 1; cycle();
    idle(); #1;
    chk("post_rst_valid", ex_valid, 1); chk("post_rst_pc", ex_pc, 32'h30C);
    cycle();

    // Randomized traffic over a small register window to provoke matches.
    for (int n = 0; n < 400; n++) begin
      drv($urandom, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
          5'($urandom_range(0, 7)), {14'($urandom), 1'b1, 1'($urandom)});
      id_valid = ($urandom_range(0, 3) != 0);
      ex_ready = ($urandom_range(0, 3) != 0);
      ex_flush = ($urandom_range(0, 9) == 0);
      exm_we = $urandom; exm_rd = 5'($urandom_range(0, 7)); exm_data = $urandom;
      wb_we = $urandom; wb_rd = 5'($urandom_range(0, 7)); wb_data = $urandom;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter XLEN, default 32, data/operand width.
REQ-002 Parameter CTRL_W, default 16, width of decoded control bundle.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 id_valid  in  1  decode holds a valid instruction.
REQ-006 id_ready  out  1  stage accepts the decode instruction this cycle.
REQ-007 id_pc / id_imm  in  XLEN each  instruction PC and sign-extended immediate.
REQ-008 id_rs1 / id_rs2 / id_rd  in  5 each  source and destination register indices.
REQ-009 id_ctrl  in  CTRL_W  decoded control; bit CTRL_MEMREAD marks a load, bit CTRL_REGWRITE marks rd write.
REQ-010 rf_raddr1 / rf_raddr2  out  5 each  register-file read addresses (synchronous read, data next cycle, same-cycle write bypass inside register file).
REQ-011 rf_rdata1 / rf_rdata2  in  XLEN each  register-file read data.
REQ-012 exm_we, exm_rd, exm_data  in  1/5/XLEN  forwarding source from EX/MEM.
REQ-013 wb_we, wb_rd, wb_data  in  1/5/XLEN  forwarding source from MEM/WB.
REQ-014 ex_flush  in  1  kill the instruction held in this stage (taken branch/jump).
REQ-015 ex_valid  out  1  valid instruction presented to execute.
REQ-016 ex_ready  in  1  execute consumes the presented instruction.
REQ-017 ex_pc, ex_imm, ex_op1, ex_op2  out  XLEN each; ex_rd  out  5; ex_ctrl  out  CTRL_W.

Function
REQ-018 rf_raddr1/2 SHALL equal id_rs1/id_rs2 combinationally every cycle.
REQ-019 Accept = id_valid & id_ready; accepted fields SHALL be registered and presented on ex_* the next cycle (latency 1).
REQ-020 States: EMPTY (ex_valid=0), LIVE (first presentation cycle, operands from rf_rdata + forwarding), HELD (stalled, operands from internal capture registers).
REQ-021 Transitions: EMPTY->LIVE on accept; LIVE/HELD->LIVE on ex_ready & accept; LIVE/HELD->EMPTY on ex_ready & no accept; LIVE->HELD on !ex_ready; HELD->HELD on !ex_ready; any state->EMPTY on ex_flush (highest priority).
REQ-022 Operand select per source: exm match (exm_we, exm_rd==rs, rs!=0) > wb match (wb_we, wb_rd==rs, rs!=0) > rf_rdata/capture; rs==0 SHALL yield 0.
REQ-023 On LIVE->HELD the forwarded operands SHALL be written to capture registers; in HELD a wb match SHALL update the capture register.
REQ-024 Load-use hazard = ex_valid & ex_ctrl[CTRL_MEMREAD] & ex_rd!=0 & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2).
REQ-025 id_ready SHALL be (state==EMPTY | ex_ready) & !hazard & !ex_flush.
REQ-026 Hazard with ex_ready high SHALL insert exactly one bubble (next state EMPTY), then accept on the following cycle.
REQ-027 ex_flush with id_valid high SHALL not accept; held instruction discarded, ex_valid=0 next cycle.
REQ-028 ex_* data outputs SHALL be stable while ex_valid & !ex_ready.

Reset
REQ-029 resetn low SHALL immediately force state EMPTY, ex_valid=0, ex_pc/ex_imm/ex_op1/ex_op2/ex_ctrl/ex_rd and capture registers to 0.
REQ-030 Reset mid-stall SHALL drop the held instruction; first accept allowed on the first edge after resetn rises.

Structure
REQ-031 Shared package cpu_pkg SHALL hold XLEN, CTRL_W, CTRL_MEMREAD/CTRL_REGWRITE bit indices and the three-state encoding.
REQ-032 One sub-module operand_fwd_mux (priority select per REQ-022) SHALL be instantiated twice.

Verification
REQ-033 Accept add x3 (rs1=x1=5, rs2=x2=7), ex_ready=1 -> next cycle ex_valid=1, ex_op1=5, ex_op2=7.
REQ-034 exm_we=1 exm_rd=1 exm_data=0xAA and wb_we=1 wb_rd=1 wb_data=0xBB in LIVE -> ex_op1=0xAA; rs1=x0 with both matching rd=0 -> ex_op1=0.
REQ-035 Load to x4 presented, next instr rs2=x4 -> id_ready=0 one cycle, one bubble (ex_valid=0), then instr presented with wb forward 0x1234 in ex_op2.
REQ-036 ex_ready=0 for 3 cycles, wb forward 0x55 to rs2 during HELD -> ex_op2=0x55 on release, other outputs unchanged.
REQ-037 ex_flush asserted in LIVE with id_valid=1 -> id_ready=0, ex_valid=0 next cycle; resetn pulsed low in HELD -> ex_valid=0 immediately.
